// File: rtl/vram_arbiter_pkg.sv
// Shared video definitions: visible-region limits and the read-owner tag encoding.
package vram_arbiter_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_GAME = 2'd2
  } owner_tag_e;

  function automatic logic in_active(input logic [10:0] h, input logic [10:0] v);
    return (h < 11'(H_ACTIVE)) && (v < 11'(V_ACTIVE));
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Request/grant/return bundle for both VRAM clients plus the single VRAM port.
interface vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_valid;
  logic [DW-1:0] disp_data;

  logic          game_req;
  logic          game_we;
  logic [AW-1:0] game_addr;
  logic [DW-1:0] game_wdata;
  logic          game_gnt;
  logic          game_valid;
  logic [DW-1:0] game_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  disp_req, disp_addr, game_req, game_we, game_addr, game_wdata, mem_rdata,
    output disp_gnt, disp_valid, disp_data, game_gnt, game_valid, game_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Client and memory side.
  modport master (
    output disp_req, disp_addr, game_req, game_we, game_addr, game_wdata, mem_rdata,
    input  disp_gnt, disp_valid, disp_data, game_gnt, game_valid, game_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vram_starve_cnt.sv
// Counts cycles a game request waits unserved; raises force_o once LIMIT waits have accrued.
module vram_starve_cnt #(
  parameter int LIMIT = 64
) (
  input  logic clk25m,
  input  logic rst_n,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d; no latch is inferred.
    cnt_d = cnt_q;
    if (gnt_i) begin
      cnt_d = '0;
    end else if (req_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one synchronous VRAM port between display fetch and game logic.
// Optional game starvation guard is built when VRAM_STARVE_GUARD_EN is defined.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          clk25m,
  input  logic          rst_n,
  input  logic [10:0]   hcnt,
  input  logic [10:0]   vcnt,
  vram_arbiter_if.slave bus,
  output logic          active,
  output logic          frame_start
);

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("vram_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic          active_q, frame_start_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] disp_data_q, game_rdata_q;
  owner_tag_e    tag0_q, tag1_q, tag_d;
  logic          disp_gnt, game_gnt, game_prio, starve_force;
  logic          disp_valid, game_valid;

`ifdef VRAM_STARVE_GUARD_EN
  vram_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk25m  (clk25m),
    .rst_n   (rst_n),
    .req_i   (bus.game_req),
    .gnt_i   (game_gnt),
    .force_o (starve_force)
  );
`else
  assign starve_force = 1'b0;
`endif

  // Grants are gated by rst_n so they drop the instant reset asserts, like the flops.
  always_comb begin
    game_prio = !active_q || starve_force;
    disp_gnt  = 1'b0;
    game_gnt  = 1'b0;
    if (rst_n) begin
      if (bus.disp_req && (!bus.game_req || !game_prio)) begin
        disp_gnt = 1'b1;
      end else if (bus.game_req) begin
        game_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (disp_gnt) begin
      tag_d = TAG_DISP;
    end else if (game_gnt && !bus.game_we) begin
      tag_d = TAG_GAME;
    end
  end

  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tag0_q        <= TAG_NONE;
      tag1_q        <= TAG_NONE;
      disp_data_q   <= '0;
      game_rdata_q  <= '0;
    end else begin
      active_q      <= in_active(hcnt, vcnt);
      frame_start_q <= (hcnt == '0) && (vcnt == '0);
      mem_en_q      <= disp_gnt || game_gnt;
      mem_we_q      <= game_gnt && bus.game_we;
      if (disp_gnt) begin
        mem_addr_q <= bus.disp_addr;
      end else if (game_gnt) begin
        mem_addr_q  <= bus.game_addr;
        mem_wdata_q <= bus.game_wdata;
      end
      // Tag stage 1 lines up with the cycle the VRAM presents read data.
      tag0_q <= tag_d;
      tag1_q <= tag0_q;
      if (disp_valid) disp_data_q  <= bus.mem_rdata;
      if (game_valid) game_rdata_q <= bus.mem_rdata;
    end
  end

  assign disp_valid = (tag1_q == TAG_DISP);
  assign game_valid = (tag1_q == TAG_GAME);

  assign bus.disp_gnt   = disp_gnt;
  assign bus.game_gnt   = game_gnt;
  assign bus.disp_valid = disp_valid;
  assign bus.game_valid = game_valid;
  assign bus.disp_data  = disp_valid ? bus.mem_rdata : disp_data_q;
  assign bus.game_rdata = game_valid ? bus.mem_rdata : game_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign active         = active_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter; the VRAM model returns addr[7:0]^8'h3C one cycle after a read.
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic        clk25m = 1'b0;
  logic        rst_n  = 1'b1;
  logic [10:0] hcnt, vcnt;
  logic        active, frame_start;

  int total = 0;
  int bad   = 0;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(64)) dut (
    .clk25m      (clk25m),
    .rst_n       (rst_n),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .bus         (bus),
    .active      (active),
    .frame_start (frame_start)
  );

  always #20 clk25m = ~clk25m;

  always @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) bus.mem_rdata <= '0;
    else if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= bus.mem_addr[7:0] ^ 8'h3C;
  end

  logic [AW-1:0] c_addr [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
  logic [DW-1:0] c_exp  [4] = '{8'h2D, 8'h1E, 8'h0F, 8'h78};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic dr, input logic [AW-1:0] da, input logic gr,
                       input logic gw, input logic [AW-1:0] ga, input logic [DW-1:0] gd);
    bus.disp_req   = dr;
    bus.disp_addr  = da;
    bus.game_req   = gr;
    bus.game_we    = gw;
    bus.game_addr  = ga;
    bus.game_wdata = gd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  int first_game, n_game, not_one, disp_after;

  initial begin
    hcnt = 11'd0;
    vcnt = 11'd0;
    drive(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0002, 8'h00);
    #5 rst_n = 1'b0;

    // Reset: every output low even with both clients requesting.
    repeat (2) @(negedge clk25m);
    #1;
    check("rst_disp_gnt", bus.disp_gnt, 0);
    check("rst_game_gnt", bus.game_gnt, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_disp_valid", bus.disp_valid, 0);
    check("rst_disp_data", bus.disp_data, 0);
    check("rst_game_valid", bus.game_valid, 0);
    check("rst_game_rdata", bus.game_rdata, 0);
    check("rst_active", active, 0);
    check("rst_frame_start", frame_start, 0);

    @(negedge clk25m);
    rst_n = 1'b1;
    idle();
    hcnt = 11'd100;
    vcnt = 11'd50;
    @(negedge clk25m);
    #1;
    check("active_on", active, 1);
    check("fs_low", frame_start, 0);
    check("idle_mem_en", bus.mem_en, 0);

    // Contended in active: display wins, data two cycles later.
    @(negedge clk25m);
    drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 8'h00);
    #1;
    check("act_disp_gnt", bus.disp_gnt, 1);
    check("act_game_gnt", bus.game_gnt, 0);
    @(negedge clk25m);
    idle();
    #1;
    check("a1_mem_en", bus.mem_en, 1);
    check("a1_mem_we", bus.mem_we, 0);
    check("a1_mem_addr", bus.mem_addr, 16'h0010);
    check("a1_disp_valid", bus.disp_valid, 0);
    @(negedge clk25m);
    #1;
    check("a2_disp_valid", bus.disp_valid, 1);
    check("a2_disp_data", bus.disp_data, 8'h2C);
    check("a2_game_valid", bus.game_valid, 0);
    @(negedge clk25m);
    #1;
    check("a3_disp_valid", bus.disp_valid, 0);
    check("a3_disp_hold", bus.disp_data, 8'h2C);
    check("a3_mem_en", bus.mem_en, 0);

    // Region edge: first blanking cycle still arbitrates with the registered active.
    @(negedge clk25m);
    hcnt = 11'd900;
    drive(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0123, 8'hA5);
    #1;
    check("edge_disp_gnt", bus.disp_gnt, 1);
    check("edge_game_gnt", bus.game_gnt, 0);
    @(negedge clk25m);
    #1;
    check("blank_active", active, 0);
    check("blank_game_gnt", bus.game_gnt, 1);
    check("blank_disp_gnt", bus.disp_gnt, 0);
    check("b1_mem_addr", bus.mem_addr, 16'h0005);
    @(negedge clk25m);
    idle();
    hcnt = 11'd100;
    #1;
    check("wr_mem_en", bus.mem_en, 1);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_addr", bus.mem_addr, 16'h0123);
    check("wr_mem_wdata", bus.mem_wdata, 8'hA5);
    check("b2_disp_valid", bus.disp_valid, 1);
    check("b2_disp_data", bus.disp_data, 8'h39);
    @(negedge clk25m);
    #1;
    check("wr_no_game_valid", bus.game_valid, 0);
    check("b3_disp_valid", bus.disp_valid, 0);
    check("b3_mem_we", bus.mem_we, 0);

    // Four back-to-back lone reads, alternating owners, in active.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk25m);
      if (i < 4) begin
        if (i % 2 == 0) drive(1'b1, c_addr[i], 1'b0, 1'b0, '0, '0);
        else            drive(1'b0, '0, 1'b1, 1'b0, c_addr[i], '0);
      end else begin
        idle();
      end
      #1;
      if (i < 4) begin
        check($sformatf("c_gnt%0d", i), (i % 2 == 0) ? bus.disp_gnt : bus.game_gnt, 1);
        check($sformatf("c_mem_en%0d", i), bus.mem_en, (i == 0) ? 0 : 1);
      end
      if (i >= 2) begin
        if ((i - 2) % 2 == 0) begin
          check($sformatf("c_dv%0d", i), bus.disp_valid, 1);
          check($sformatf("c_gv%0d", i), bus.game_valid, 0);
          check($sformatf("c_dd%0d", i), bus.disp_data, c_exp[i-2]);
        end else begin
          check($sformatf("c_gv%0d", i), bus.game_valid, 1);
          check($sformatf("c_dv%0d", i), bus.disp_valid, 0);
          check($sformatf("c_gd%0d", i), bus.game_rdata, c_exp[i-2]);
        end
      end
    end

    // Frame start pulse.
    @(negedge clk25m);
    hcnt = 11'd0;
    vcnt = 11'd0;
    @(negedge clk25m);
    hcnt = 11'd1;
    #1;
    check("fs_pulse", frame_start, 1);
    check("fs_active", active, 1);
    @(negedge clk25m);
    hcnt = 11'd100;
    #1;
    check("fs_drop", frame_start, 0);

    // Continuous contention in active.
    first_game = -1;
    n_game     = 0;
    not_one    = 0;
    disp_after = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk25m);
      drive(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 8'h00);
      #1;
      if (bus.game_gnt) begin
        n_game++;
        if (first_game < 0) first_game = i;
      end
      if (bus.game_gnt == bus.disp_gnt) not_one++;
      if (i == 65) disp_after = int'(bus.disp_gnt);
    end
    @(negedge clk25m);
    idle();
`ifdef VRAM_STARVE_GUARD_EN
    check("starve_first", first_game, 64);
    check("starve_count", n_game, 1);
    check("starve_resume", disp_after, 1);
`else
    check("no_starve_gnt", n_game, 0);
`endif
    check("one_gnt", not_one, 0);

    // Reset one cycle after a read handshake discards it.
    @(negedge clk25m);
    drive(1'b1, 16'h0066, 1'b0, 1'b0, '0, '0);
    #1;
    check("d0_disp_gnt", bus.disp_gnt, 1);
    @(negedge clk25m);
    idle();
    rst_n = 1'b0;
    #1;
    check("d1_mem_en", bus.mem_en, 0);
    check("d1_disp_valid", bus.disp_valid, 0);
    check("d1_active", active, 0);
    @(negedge clk25m);
    #1;
    check("d2_disp_valid", bus.disp_valid, 0);
    check("d2_disp_data", bus.disp_data, 0);
    check("d2_mem_addr", bus.mem_addr, 0);
    @(negedge clk25m);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk25m);
      #1;
      check($sformatf("post_rst_dv%0d", i), bus.disp_valid, 0);
      check($sformatf("post_rst_gv%0d", i), bus.game_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
